io_hub: RTL
===========

# io_hub

Parametrised memory-mapped I/O controller for the single-cycle MIPS core. It replaces the fixed switch/LED/segment I/O path and adds three things:
- debounced buttons, with a sticky press-event register;
- a free-running cycle timer;
- a display control register.

It sits between the CPU's IORead/IOWrite decode and the board pins and displays driver.

## Interface
Parameters:
- NUM_BTN, 4: number of button channels (1..16).
- SW_WIDTH, 24: switch input width (1..32).
- LED_WIDTH, 24: LED output width (1..32).
- DEB_CYCLES, 20000: consecutive stable cycles required to accept a button change (≥2).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  5  word-aligned register offset (ALU_result[4:0]); bits [1:0] ignored.
- wdata  in  32  write data (Read_data_2).
- io_read  in  1  read strobe.
- io_write  in  1  write strobe.
- rdata  out  32  read data.
- switch  in  SW_WIDTH  raw switch pins.
- button  in  NUM_BTN  raw button pins, active-high.
- led_out  out  LED_WIDTH  LED register.
- seg_data  out  32  eight hex digits for the display driver.
- digit_en  out  8  per-digit enable.
- blink_en  out  1  display blink request.
- irq  out  1  OR of (BTN_EVENT & EVENT_MASK).

## Operation
Register map (byte offsets):
- 0x00 SW (RO): synchronised switches, zero-extended.
- 0x04 BTN_STATE (RO): debounced button levels, zero-extended.
- 0x08 BTN_EVENT (RW1C): sticky bit per button, set on each debounced 0→1 transition. Writing 1 to a bit clears it; writing 0 has no effect.
- 0x0C LED (RW): bits above LED_WIDTH read 0.
- 0x10 SEG (RW): drives seg_data.
- 0x14 CTRL (RW): [0] blink_en; [15:8] digit_en; [31:16] EVENT_MASK, of which bits ≥ NUM_BTN read 0. Other bits read 0.
- 0x18 TIMER (RW): 32-bit cycle counter. A write loads wdata.
- 0x1C and any unmapped offset: read 0, writes ignored.

Input synchronisation:
- switch and button each pass through a 2-flop synchroniser before any use.

Debounce, per channel (counter width = clog2(DEB_CYCLES)):
- While sync equals stable, the counter holds 0.
- While sync differs from stable, the counter increments each cycle.
- When the counter equals DEB_CYCLES-1 with sync still different, stable takes sync and the counter clears.
- Any cycle where sync equals stable clears the counter; this is glitch rejection.

TIMER:
- Increments every cycle and wraps from 0xFFFFFFFF to 0.

Reads and writes:
- rdata is combinational: the register selected by addr when io_read=1, otherwise 0.
- A write takes effect on the clock edge while io_write=1.
- If io_read and io_write are both high, the read returns the pre-write value.

Simultaneous events:
- Event set and W1C clear of the same bit in the same cycle: set wins, bit remains 1.
- TIMER write and increment in the same cycle: the written value wins; counting resumes from it next cycle.

Reset values:
- led_out=0, seg_data=0, digit_en=0xFF, blink_en=0, irq=0.
- EVENT_MASK=0, BTN_EVENT=0, TIMER=0.
- Synchronisers, stable levels and counters all 0.
- rdata=0 while io_read=0.

Reset asserted mid-operation:
- All state returns to reset values immediately (asynchronously); pending events are lost.

## Timing
- Switch pin change is visible in SW 2 cycles later.
- Button pin change with no bounce is visible in BTN_STATE 2+DEB_CYCLES cycles later. BTN_EVENT and irq update on that same edge.
- The write-to-output latency of LED, SEG and CTRL is one edge.
- The W1C clear is visible on the next read cycle after the edge.
- irq is registered-path combinational on BTN_EVENT and EVENT_MASK, with no extra cycle.
- After reset deasserts, TIMER reads N on the N-th rising edge.

## Test plan
- Reset: hold reset=0 with random pins → led_out=0, seg_data=0, digit_en=0xFF, blink_en=0, irq=0. Read TIMER after release → 0 plus the elapsed cycles.
- Debounce (DEB_CYCLES=4):
  - raise button[1] cleanly → BTN_STATE=0x2 exactly 6 cycles after the pin edge, BTN_EVENT=0x2;
  - 3-cycle pulse on button[0] → BTN_STATE and BTN_EVENT unchanged.
- W1C race:
  - with BTN_EVENT=0x3, write 0x1 → reads 0x2;
  - write 0x2 on the same edge a new button[1] press is accepted → BTN_EVENT bit1 stays 1.
- Registers: write LED=0xFFFFFFFF with LED_WIDTH=24 → led_out=0xFFFFFF, read 0x00FFFFFF. Write CTRL=0x00020F01 → blink_en=1, digit_en=0x0F, and irq asserts once button[1] is pressed.
- TIMER:
  - write 0xFFFFFFFE, then read on the following cycles → 0xFFFFFFFF, 0x0, 0x1;
  - read offset 0x1C and 0x00 with io_read=0 → rdata=0.
- Async reset mid-debounce: assert reset while a button counter is at 2 → all state clears within the cycle. After release, the pin still high → accepted DEB_CYCLES+2 cycles later.

Source files
------------

// File: rtl/io_hub.sv
// Memory-mapped I/O hub for the single-cycle MIPS core: switches, debounced
// buttons with sticky events, LEDs, display control and a free-running timer.
module io_hub #(
    parameter int unsigned NUM_BTN    = 4,
    parameter int unsigned SW_WIDTH   = 24,
    parameter int unsigned LED_WIDTH  = 24,
    parameter int unsigned DEB_CYCLES = 20000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [4:0]           addr,
    input  logic [31:0]          wdata,
    input  logic                 io_read,
    input  logic                 io_write,
    output logic [31:0]          rdata,
    input  logic [SW_WIDTH-1:0]  switch,
    input  logic [NUM_BTN-1:0]   button,
    output logic [LED_WIDTH-1:0] led_out,
    output logic [31:0]          seg_data,
    output logic [7:0]           digit_en,
    output logic                 blink_en,
    output logic                 irq
);
    localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    localparam logic [2:0] R_SW   = 3'd0;
    localparam logic [2:0] R_BTN  = 3'd1;
    localparam logic [2:0] R_EVT  = 3'd2;
    localparam logic [2:0] R_LED  = 3'd3;
    localparam logic [2:0] R_SEG  = 3'd4;
    localparam logic [2:0] R_CTRL = 3'd5;
    localparam logic [2:0] R_TMR  = 3'd6;

    logic [2:0]                     sel;
    logic [SW_WIDTH-1:0]            sw_s1_q, sw_s2_q;
    logic [NUM_BTN-1:0]             btn_s1_q, btn_s2_q;
    logic [NUM_BTN-1:0]             stable_q, stable_d;
    logic [NUM_BTN-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_BTN-1:0]             event_q, event_d, evt_clr;
    logic [LED_WIDTH-1:0]           led_q, led_d;
    logic [31:0]                    seg_q, seg_d;
    logic [7:0]                     digit_q, digit_d;
    logic                           blink_q, blink_d;
    logic [NUM_BTN-1:0]             mask_q, mask_d;
    logic [31:0]                    timer_q, timer_d;
    logic                           unused_addr_c;

    assign sel           = addr[4:2];
    assign unused_addr_c = ^addr[1:0];

    // Debounce: a channel flips only after DEB_CYCLES consecutive differing samples
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            cnt_d[i] = '0;
            if (btn_s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = btn_s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Register writes; a new rising event overrides a same-cycle W1C clear
    always_comb begin
        led_d   = led_q;
        seg_d   = seg_q;
        digit_d = digit_q;
        blink_d = blink_q;
        mask_d  = mask_q;
        timer_d = timer_q + 32'd1;
        evt_clr = '0;
        if (io_write) begin
            case (sel)
                R_EVT:  evt_clr = wdata[NUM_BTN-1:0];
                R_LED:  led_d   = wdata[LED_WIDTH-1:0];
                R_SEG:  seg_d   = wdata;
                R_CTRL: begin
                    blink_d = wdata[0];
                    digit_d = wdata[15:8];
                    mask_d  = wdata[16 +: NUM_BTN];
                end
                R_TMR:  timer_d = wdata;
                default: ;
            endcase
        end
        event_d = (event_q & ~evt_clr) | (stable_d & ~stable_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            event_q  <= '0;
            led_q    <= '0;
            seg_q    <= '0;
            digit_q  <= 8'hFF;
            blink_q  <= 1'b0;
            mask_q   <= '0;
            timer_q  <= '0;
        end else begin
            sw_s1_q  <= switch;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= button;
            btn_s2_q <= btn_s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            event_q  <= event_d;
            led_q    <= led_d;
            seg_q    <= seg_d;
            digit_q  <= digit_d;
            blink_q  <= blink_d;
            mask_q   <= mask_d;
            timer_q  <= timer_d;
        end
    end

    // Combinational read mux; a concurrent write is seen only after the edge
    always_comb begin
        rdata = '0;
        if (io_read) begin
            case (sel)
                R_SW:   rdata = 32'(sw_s2_q);
                R_BTN:  rdata = 32'(stable_q);
                R_EVT:  rdata = 32'(event_q);
                R_LED:  rdata = 32'(led_q);
                R_SEG:  rdata = seg_q;
                R_CTRL: rdata = {16'(mask_q), digit_q, 7'd0, blink_q};
                R_TMR:  rdata = timer_q;
                default: rdata = '0;
            endcase
        end
    end

    assign led_out  = led_q;
    assign seg_data = seg_q;
    assign digit_en = digit_q;
    assign blink_en = blink_q;
    assign irq      = |(event_q & mask_q);

endmodule
